fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin arbiter sharing the single write port of the async FIFO among
//   NUM_REQ requesters in the write clock domain. Grants whole bursts and drives
//   the FIFO wr_en/data. Obeys the FIFO full flag.
//   Sits between the write-side producers and the FIFO write logic.
//   Single clock: wr_clk. No CDC inside this block.
// PARAMETERS
//   NUM_REQ    4   number of requesters (>=2)
//   DATA_W     8   FIFO data width
//   MAX_BEATS  8   max beats per grant before forced re-arbitration (>=2)
// PORTS
//   wr_clk        in   1               write-domain clock, all logic on posedge
//   rst           in   1               synchronous reset, active-high
//   req_valid     in   NUM_REQ         requester i has a beat on req_data[i]
//   req_last      in   NUM_REQ         beat of requester i is final beat of burst
//   req_data      in   NUM_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ready     out  NUM_REQ         beat of requester i accepted this cycle
//   fifo_full     in   1               registered full flag from FIFO write side
//   fifo_wr_en    out  1               write request to FIFO
//   fifo_wr_data  out  DATA_W          write data to FIFO
//   grant         out  NUM_REQ         one-hot current owner, 0 when idle
//   busy          out  1               1 while in BURST
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
//     While rst=1, fifo_wr_en, req_ready forced 0. Reset mid-burst abandons the
//     burst; beats already accepted stay in the FIFO.
//   - FSM IDLE: if |req_valid, pick the first i with req_valid[i], scanning
//     rr_ptr, rr_ptr+1, ... mod NUM_REQ. Register grant=onehot(i), beat_cnt=0,
//     go BURST. Arbitration latency is 1 cycle; no write occurs in IDLE.
//   - FSM BURST (owner k): fifo_wr_en = req_valid[k] (combinational);
//     fifo_wr_data = req_data[k]; req_ready[k] = !fifo_full; others' ready = 0.
//   - Accepted beat = fifo_wr_en && !fifo_full. This matches the FIFO pointer
//     increment rule.
//   - On accepted beat: beat_cnt++. If req_last[k] or beat_cnt==MAX_BEATS-1,
//     go IDLE, grant=0, rr_ptr=(k+1) mod NUM_REQ.
//   - Exactly one IDLE cycle between consecutive bursts.
//   - Owner drops req_valid mid-burst: stay in BURST, hold grant, no timeout.
//   - fifo_full=1: no beat accepted and grant held. Data and valid from the
//     owner must stay stable until accepted.
//   - Forced split at MAX_BEATS: the owner must re-request; its remaining beats
//     compete again with lowest priority.
//   - Non-owners' req_valid/req_last ignored. req_last with req_valid=0 ignored.
//   - fifo_wr_data=0 when IDLE. beat_cnt width $clog2(MAX_BEATS), never wraps.
//   - Outputs depend only on registered state plus owner inputs/fifo_full.
//     No path from a non-owner input to any output.
// TESTING
//   1. rst=1 for 2 cycles with all req_valid=1 -> grant=0, busy=0,
//      fifo_wr_en=0, req_ready=0.
//   2. NUM_REQ=4, req 1 sends 3 beats A1,B2,C3 (last on C3) -> grant=4'b0010 one
//      cycle after valid; fifo_wr_en for 3 cycles with data A1,B2,C3; then IDLE.
//   3. All 4 requesters continuously send 2-beat bursts -> grant order
//      0,1,2,3,0,1 with one IDLE cycle between bursts.
//   4. fifo_full=1 for 5 cycles after beat 1 of a 4-beat burst -> req_ready=0,
//      data held, grant held; beats 2-4 accepted after full drops.
//   5. MAX_BEATS=8, req 0 streams 20 beats without last, req 2 waiting ->
//      after beat 8 grant=4'b0100 (after IDLE), then req 0 regains the grant.
//   6. rst=1 on 2nd beat of a 4-beat burst from req 3 -> next cycle IDLE,
//      grant=0; with all requesting, next grant=4'b0001 (rr_ptr=0).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of the async FIFO write port.
// Grants whole bursts to one requester at a time and honours fifo_full.
// A burst ends when the owner marks its last beat, or when MAX_BEATS beats
// have been accepted. The pointer then moves past the owner so everyone
// else is scanned first.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no owner; pick the next requester round-robin from rr_ptr
// S_BURST | owner_q holds the write port; beats pass straight through
//
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 8
) (
  input  logic                      wr_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BEATS);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic [DATA_W-1:0]    data_arr [NUM_REQ];
  logic                 own_valid;
  logic                 own_last;
  logic [DATA_W-1:0]    own_data;
  logic                 beat_accept;
  logic                 burst_end;

  logic                 pick_valid;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W:0]       cand;

  // Unpack the flat requester data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Only the owner's lines are ever looked at during a burst.
  always_comb begin
    own_valid = req_valid[owner_q];
    own_last  = req_last[owner_q];
    own_data  = data_arr[owner_q];
  end

  // A beat moves into the FIFO exactly when the FIFO bumps its write pointer.
  always_comb begin
    beat_accept = (state_q == S_BURST) && own_valid && !fifo_full;
    burst_end   = beat_accept && (own_last || (beat_cnt_q == LAST_BEAT));
  end

  // Round-robin scan starting at rr_ptr. Walking offsets from the far end
  // down lets the nearest valid requester overwrite the pick, so no break.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(off);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (req_valid[cand[PTR_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and close bursts in BURST.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d    = S_BURST;
          grant_d    = NUM_REQ'(1) << pick_idx;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end

      S_BURST: begin
        if (burst_end) begin
          // Clear rather than increment so the counter never wraps.
          state_d    = S_IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);
        end else if (beat_accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register with synchronous reset; a burst in flight is simply dropped.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Write port and handshakes: registered owner plus owner inputs only.
  // Non-owners can never reach an output. Reset blocks any write in flight.
  always_comb begin
    busy         = (state_q == S_BURST);
    grant        = grant_q;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    req_ready    = '0;
    if (state_q == S_BURST) begin
      fifo_wr_data = own_data;
      if (!rst) begin
        fifo_wr_en = own_valid;
        if (!fifo_full) begin
          req_ready = grant_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: fixed vectors, directed corner sequences and
// random traffic, all compared against a burst-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic          wr_clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic [N-1:0]  grant;
  logic          busy;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: who owns the port (-1 = nobody), where the next scan
  // starts and how many beats the current owner has delivered.
  int m_own   = -1;
  int m_rr    = 0;
  int m_beats = 0;

  logic [17:0] dut_out;

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        f;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl [7];

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .wr_clk       (wr_clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant        (grant),
    .busy         (busy)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [17:0] mk(input logic [3:0] g, input logic bz,
                                     input logic we, input logic [7:0] d,
                                     input logic [3:0] rdy);
    return {g, bz, we, d, rdy};
  endfunction

  // Expected outputs for the current inputs and model state.
  function automatic logic [17:0] model_out();
    logic [3:0] g;
    logic [3:0] rdy;
    logic       bz;
    logic       we;
    logic [7:0] d;
    g = '0; rdy = '0; bz = 1'b0; we = 1'b0; d = '0;
    if (m_own >= 0) begin
      bz = 1'b1;
      g  = 4'(1 << m_own);
      d  = req_data[m_own*8 +: 8];
      if (!rst) begin
        we = req_valid[m_own];
        if (!fifo_full) rdy = g;
      end
    end
    return {g, bz, we, d, rdy};
  endfunction

  // Advance the model by one clock using the inputs applied this cycle.
  task automatic model_step();
    int c;
    if (rst) begin
      m_own = -1; m_rr = 0; m_beats = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (req_valid[c] && m_own < 0) m_own = c;
      end
      m_beats = 0;
    end else if (req_valid[m_own] && !fifo_full) begin
      m_beats++;
      if (req_last[m_own] || m_beats == MB) begin
        m_rr    = (m_own + 1) % N;
        m_own   = -1;
        m_beats = 0;
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1ns later, compare to model.
  task automatic cyc(input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic [31:0] d, input logic f);
    @(negedge wr_clk);
    rst = r; req_valid = v; req_last = l; req_data = d; fifo_full = f;
    #1;
    dut_out = {grant, busy, fifo_wr_en, fifo_wr_data, req_ready};
    check("model gnt/busy/we/data/rdy", 32'(dut_out), 32'(model_out()));
    model_step();
  endtask

  function automatic int oh_idx(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  int          sent [N];
  int          starts [$];
  logic [3:0]  prev_g;
  logic [3:0]  lv;
  logic [3:0]  vv;
  int          first_beats;
  int          got;
  int          exp_order3 [6];
  int          exp_order5 [3];

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;

    tbl[0] = '{1'b1, 4'hF, 4'h0, 32'h44332211, 1'b0, mk(4'h0, 0, 0, 8'h00, 4'h0)};
    tbl[1] = '{1'b1, 4'hF, 4'h0, 32'h44332211, 1'b0, mk(4'h0, 0, 0, 8'h00, 4'h0)};
    tbl[2] = '{1'b0, 4'h2, 4'h0, 32'h0000A100, 1'b0, mk(4'h0, 0, 0, 8'h00, 4'h0)};
    tbl[3] = '{1'b0, 4'h2, 4'h0, 32'h0000A100, 1'b0, mk(4'h2, 1, 1, 8'hA1, 4'h2)};
    tbl[4] = '{1'b0, 4'h2, 4'h0, 32'h0000B200, 1'b0, mk(4'h2, 1, 1, 8'hB2, 4'h2)};
    tbl[5] = '{1'b0, 4'h2, 4'h2, 32'h0000C300, 1'b0, mk(4'h2, 1, 1, 8'hC3, 4'h2)};
    tbl[6] = '{1'b0, 4'h0, 4'h0, 32'h00000000, 1'b0, mk(4'h0, 0, 0, 8'h00, 4'h0)};

    // Reset with everyone requesting, then one 3-beat burst from requester 1.
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].f);
      check($sformatf("tbl%0d", i), 32'(dut_out), 32'(tbl[i].exp));
    end

    // All four stream 2-beat bursts: grant order 0,1,2,3,0,1.
    cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < N; i++) sent[i] = 0;
    starts.delete();
    prev_g = '0;
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < N; i++) lv[i] = (sent[i] % 2 == 1);
      cyc(1'b0, 4'hF, lv, $urandom, 1'b0);
      for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) sent[i]++;
      if (grant != 0 && prev_g == 0) starts.push_back(oh_idx(grant));
      prev_g = grant;
    end
    exp_order3 = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      got = (i < starts.size()) ? starts[i] : 99;
      check($sformatf("rr_order[%0d]", i), 32'(got), 32'(exp_order3[i]));
    end

    // FIFO full for 5 cycles after beat 1 of a 4-beat burst from requester 2.
    cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
    cyc(1'b0, 4'h4, 4'h0, 32'h00D00000, 1'b0);
    cyc(1'b0, 4'h4, 4'h0, 32'h00D00000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, 4'h4, 4'h0, 32'h00D10000, 1'b1);
      check("full_hold gnt/rdy/data", {20'h0, grant, req_ready, fifo_wr_data},
            {20'h0, 4'h4, 4'h0, 8'hD1});
    end
    cyc(1'b0, 4'h4, 4'h0, 32'h00D10000, 1'b0);
    cyc(1'b0, 4'h4, 4'h0, 32'h00D20000, 1'b0);
    cyc(1'b0, 4'h4, 4'h4, 32'h00D30000, 1'b0);
    check("full_last data/we", {23'h0, fifo_wr_en, fifo_wr_data}, {23'h0, 1'b1, 8'hD3});
    cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    check("full_after idle", {27'h0, grant, busy}, 32'h0);

    // Requester 0 streams 20 beats without last while requester 2 waits.
    cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < N; i++) sent[i] = 0;
    starts.delete();
    prev_g = '0;
    first_beats = 0;
    for (int c = 0; c < 40; c++) begin
      vv = {1'b0, sent[2] == 0, 1'b0, sent[0] < 20};
      lv = {1'b0, sent[2] == 0, 2'b00};
      cyc(1'b0, vv, lv, {8'h00, 8'h20 + 8'(sent[2]), 8'h00, 8'(sent[0])}, 1'b0);
      if (grant != 0 && prev_g == 0) starts.push_back(oh_idx(grant));
      prev_g = grant;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          sent[i]++;
          if (i == 0 && starts.size() == 1) first_beats++;
        end
      end
    end
    exp_order5 = '{0, 2, 0};
    for (int i = 0; i < 3; i++) begin
      got = (i < starts.size()) ? starts[i] : 99;
      check($sformatf("split_order[%0d]", i), 32'(got), 32'(exp_order5[i]));
    end
    check("split_first_beats", 32'(first_beats), 32'(MB));
    check("split_total_beats", 32'(sent[0]), 32'd20);

    // Reset on beat 2 of a burst from requester 3.
    cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
    cyc(1'b0, 4'h8, 4'h0, 32'hE0000000, 1'b0);
    cyc(1'b0, 4'h8, 4'h0, 32'hE0000000, 1'b0);
    check("rst_mid beat1 we", 32'(fifo_wr_en), 32'd1);
    cyc(1'b1, 4'h8, 4'h0, 32'hE1000000, 1'b0);
    check("rst_mid we/rdy", {27'h0, fifo_wr_en, req_ready}, 32'h0);
    cyc(1'b0, 4'hF, 4'h0, 32'h44332211, 1'b0);
    check("rst_mid idle gnt/busy", {27'h0, grant, busy}, 32'h0);
    cyc(1'b0, 4'hF, 4'h0, 32'h44332211, 1'b0);
    check("rst_mid regrant", 32'(grant), 32'h1);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      cyc($urandom_range(0, 99) == 0,
          4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15) & $urandom_range(0, 15)),
          $urandom,
          $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
